noc_reg_responder: RTL and testbench

Register-file responder that sits on the IP side of one network interface unit port. It pops request packets from the port's rx queue, executes single-word reads and writes against an internal 32-bit register bank, and pushes one response packet per request into the port's tx queue. It is the responder end of the NOC request/response protocol that the NIU carries between IP blocks.

---
 rtl/noc_reg_responder_pkg.sv | 63 ++++++
 rtl/noc_reg_responder_if.sv | 28 ++
 rtl/noc_req_decode.sv | 51 +++++
 rtl/noc_reg_responder.sv | 135 +++++++++++++
 tb/tb_noc_reg_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_reg_responder_pkg.sv
// noc_reg_responder_pkg
// Shared definitions for the NOC register responder:
//   - the noc_packet type (288-bit, byte j = bits [8j+7:8j])
//   - request/response opcodes and lengths
//   - header byte offsets
//   - the FSM state type
//   - a helper that assembles a response packet
package noc_reg_responder_pkg;

  localparam int PKT_W = 288;
  // Only the first 12 bytes of a request carry meaning.
  localparam int HDR_W = 96;

  typedef logic [PKT_W-1:0] noc_packet;

  // Header byte offsets
  localparam int B_LEN  = 0;
  localparam int B_DST  = 1;
  localparam int B_SRC  = 2;
  localparam int B_OP   = 3;
  localparam int B_ADDR = 4;
  localparam int B_DATA = 8;

  // Opcodes
  localparam logic [7:0] OP_WR_REQ = 8'h01;
  localparam logic [7:0] OP_RD_REQ = 8'h02;
  localparam logic [7:0] OP_WR_ACK = 8'h81;
  localparam logic [7:0] OP_RD_DAT = 8'h82;
  localparam logic [7:0] OP_ERR    = 8'hEE;

  // Packet lengths in bytes
  localparam logic [7:0] LEN_WR_REQ = 8'd12;
  localparam logic [7:0] LEN_RD_REQ = 8'd8;
  localparam logic [7:0] LEN_WR_ACK = 8'd8;
  localparam logic [7:0] LEN_RD_DAT = 8'd12;
  localparam logic [7:0] LEN_ERR    = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  // Bytes past the length stay zero.
  // The data word is only placed when the response is 12 bytes long.
  function automatic noc_packet build_rsp(input logic [7:0]  len,
                                          input logic [7:0]  op,
                                          input logic [7:0]  dst,
                                          input logic [7:0]  src,
                                          input logic [31:0] addr,
                                          input logic [31:0] data);
    noc_packet p;
    p = '0;
    p[8*B_LEN  +: 8]  = len;
    p[8*B_DST  +: 8]  = dst;
    p[8*B_SRC  +: 8]  = src;
    p[8*B_OP   +: 8]  = op;
    p[8*B_ADDR +: 32] = addr;
    if (len == LEN_RD_DAT) p[8*B_DATA +: 32] = data;
    return p;
  endfunction

endpackage

// File: rtl/noc_reg_responder_if.sv
// noc_reg_responder_if
// Handshake bundle between one NIU port and the IP-side responder.
//
// Signals:
//   rx_av / rx_re / rx_dat : the rx queue
//                            (head valid / pop / head packet)
//   tx_av / tx_re / tx_dat : the tx queue
//                            (response valid / queue not full / response packet)
//
// Modports:
//   master : NIU side
//   slave  : responder side
interface noc_reg_responder_if;
  import noc_reg_responder_pkg::*;

  logic      rx_av;
  logic      rx_re;
  noc_packet rx_dat;
  logic      tx_av;
  logic      tx_re;
  noc_packet tx_dat;

  modport master (output rx_av, rx_dat, tx_re,
                  input  rx_re, tx_av, tx_dat);

  modport slave  (input  rx_av, rx_dat, tx_re,
                  output rx_re, tx_av, tx_dat);
endinterface

// File: rtl/noc_req_decode.sv
// noc_req_decode
// Combinational decode of a captured request header.
//
// Ports:
//   req      : first 12 bytes of the request
//   is_read  : well-formed read to a mapped register
//   is_write : well-formed write to a mapped register
//   err      : anything else (bad opcode, length, alignment or range)
//   idx      : register index, address[9:2]
//   wdata    : write data
//
// Parameter:
//   NUM_REGS : size of the register bank
module noc_req_decode
  import noc_reg_responder_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [HDR_W-1:0] req,
  output logic             is_read,
  output logic             is_write,
  output logic             err,
  output logic [7:0]       idx,
  output logic [31:0]      wdata
);

  localparam logic [31:0] ADDR_LIM = 32'(NUM_REGS * 4);

  logic [7:0]  len;
  logic [7:0]  op;
  logic [31:0] addr;
  logic        addr_ok;
  logic        unused_hdr;

  assign len   = req[8*B_LEN  +: 8];
  assign op    = req[8*B_OP   +: 8];
  assign addr  = req[8*B_ADDR +: 32];
  assign wdata = req[8*B_DATA +: 32];

  // Routing bytes are handled by the top, not by decode.
  assign unused_hdr = ^req[8*B_DST +: 16];

  // The range test uses the full 32-bit address.
  // This keeps aliases with upper bits set from reaching a register.
  assign addr_ok  = (addr[1:0] == 2'b00) && (addr < ADDR_LIM);
  assign is_write = (op == OP_WR_REQ) && (len == LEN_WR_REQ) && addr_ok;
  assign is_read  = (op == OP_RD_REQ) && (len == LEN_RD_REQ) && addr_ok;
  assign err      = ~(is_write | is_read);
  assign idx      = addr[9:2];

endmodule

// File: rtl/noc_reg_responder.sv
// noc_reg_responder
// IP-side register-file responder for one NIU port.
// It pops a request, executes a single-word read or write on the register
// bank, and pushes one response. Only one request is in flight at a time.
// Minimum cost is 3 cycles per request (IDLE -> EXEC -> RESP).
//
// Ports:
//   ipclk    : clock
//   rst      : asynchronous active-high reset
//   prt_addr : NIU address of this port; source address in responses
//   prt_num  : NIU port number of this port; source port in responses
//   bus      : rx/tx queue handshake (slave modport)
//   reg_q    : live register contents
//   reg_wr   : one-hot, one-cycle write strobe
//
// Build option:
//   NOC_RESP_ERR_EN
//     defined   : a bad request gets an 0xEE response
//     undefined : a bad request is dropped silently
module noc_reg_responder
  import noc_reg_responder_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                          ipclk,
  input  logic                          rst,
  input  logic [3:0]                    prt_addr,
  input  logic [3:0]                    prt_num,
  noc_reg_responder_if.slave            bus,
  output logic [NUM_REGS-1:0][31:0]     reg_q,
  output logic [NUM_REGS-1:0]           reg_wr
);

  state_t           state;
  logic [HDR_W-1:0] req_q;
  noc_packet        rsp_q;
  logic             tx_av_q;

  logic             dec_read;
  logic             dec_write;
  logic             dec_err;
  logic [7:0]       dec_idx;
  logic [31:0]      dec_wdata;
  logic [31:0]      rdata;
  noc_packet        rsp_ok;
  logic             unused_rx_hi;

  noc_req_decode #(.NUM_REGS(NUM_REGS)) u_dec (
    .req      (req_q),
    .is_read  (dec_read),
    .is_write (dec_write),
    .err      (dec_err),
    .idx      (dec_idx),
    .wdata    (dec_wdata)
  );

  // Bytes past the 12-byte header are never looked at.
  assign unused_rx_hi = ^bus.rx_dat[PKT_W-1:HDR_W];

  // Pop is combinational so a waiting request is taken on the first IDLE edge.
  assign bus.rx_re  = (state == ST_IDLE) && bus.rx_av && !rst;
  assign bus.tx_av  = tx_av_q;
  assign bus.tx_dat = rsp_q;

  // Read data is the pre-write value.
  // No write can land in the same EXEC cycle.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec_idx == 8'(i)) rdata = reg_q[i];
    end
  end

  // dec_read is implied when the request is not an error and not a write.
  assign rsp_ok = build_rsp(dec_write ? LEN_WR_ACK : LEN_RD_DAT,
                            dec_write ? OP_WR_ACK  : OP_RD_DAT,
                            req_q[8*B_SRC +: 8], {prt_addr, prt_num},
                            req_q[8*B_ADDR +: 32], rdata);

  always_ff @(posedge ipclk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      tx_av_q <= 1'b0;
      reg_wr  <= '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= RESET_VAL;
    end else begin
      reg_wr <= '0;
      unique case (state)
        // Stage boundary: capture the request
        ST_IDLE: begin
          if (bus.rx_av) begin
            req_q <= bus.rx_dat[HDR_W-1:0];
            state <= ST_EXEC;
          end
        end
        // Stage boundary: execute and build the response
        ST_EXEC: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (dec_write && dec_idx == 8'(i)) begin
              reg_q[i]  <= dec_wdata;
              reg_wr[i] <= 1'b1;
            end
          end
          if (!dec_err) begin
            rsp_q   <= rsp_ok;
            tx_av_q <= 1'b1;
            state   <= ST_RESP;
          end else begin
`ifdef NOC_RESP_ERR_EN
            rsp_q   <= build_rsp(LEN_ERR, OP_ERR, req_q[8*B_SRC +: 8],
                                 {prt_addr, prt_num},
                                 req_q[8*B_ADDR +: 32], 32'h0);
            tx_av_q <= 1'b1;
            state   <= ST_RESP;
`else
            state   <= ST_IDLE;
`endif
          end
        end
        // Stage boundary: hold the response until the tx queue takes it
        ST_RESP: begin
          if (bus.tx_re) begin
            tx_av_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_reg_responder.sv
module tb_noc_reg_responder;
  import noc_reg_responder_pkg::*;

  localparam int          NREG = 16;
  localparam logic [31:0] RV   = 32'hA5A5_0F0F;
  localparam logic [3:0]  PA   = 4'hA;
  localparam logic [3:0]  PN   = 4'h3;

  logic                   ipclk = 1'b0;
  logic                   rst;
  logic [3:0]             prt_addr;
  logic [3:0]             prt_num;
  logic [NREG-1:0][31:0]  reg_q;
  logic [NREG-1:0]        reg_wr;

  noc_reg_responder_if bus();

  noc_reg_responder #(.NUM_REGS(NREG), .RESET_VAL(RV)) dut (
    .ipclk    (ipclk),
    .rst      (rst),
    .prt_addr (prt_addr),
    .prt_num  (prt_num),
    .bus      (bus),
    .reg_q    (reg_q),
    .reg_wr   (reg_wr)
  );

  always #5 ipclk = ~ipclk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mregs [NREG];

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request packet; bytes past the meaningful ones are random junk.
  function automatic noc_packet mk(input logic [7:0] len, input logic [7:0] src,
                                   input logic [7:0] op, input logic [31:0] addr,
                                   input logic [31:0] data);
    noc_packet p;
    for (int w = 0; w < 9; w++) p[32*w +: 32] = $urandom();
    p[7:0]   = len;
    p[15:8]  = {PA, PN};
    p[23:16] = src;
    p[31:24] = op;
    p[63:32] = addr;
    p[95:64] = data;
    return p;
  endfunction

  // Reference model.
  // Applies the request to mregs and returns whether a response is due.
  // r receives the expected response; wr receives the expected write strobe.
  function automatic bit model(input noc_packet p, output noc_packet r,
                               output logic [NREG-1:0] wr);
    int unsigned len, op, a;
    bit          mapped;
    len    = p[7:0];
    op     = p[31:24];
    a      = p[63:32];
    mapped = (a % 4 == 0) && (a < NREG * 4);
    r = '0;
    wr = '0;
    r[15:8]  = p[23:16];
    r[23:16] = {PA, PN};
    r[63:32] = a;
    if (op == 1 && len == 12 && mapped) begin
      mregs[a/4] = p[95:64];
      wr[a/4]    = 1'b1;
      r[7:0]     = 8;
      r[31:24]   = 8'h81;
      return 1;
    end
    if (op == 2 && len == 8 && mapped) begin
      r[7:0]   = 12;
      r[31:24] = 8'h82;
      r[95:64] = mregs[a/4];
      return 1;
    end
    r[7:0]   = 8;
    r[31:24] = 8'hEE;
`ifdef NOC_RESP_ERR_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  function automatic logic [511:0] mvec();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[32*i +: 32] = mregs[i];
    return v;
  endfunction

  // Starts 1 time unit after a rising edge with the DUT idle.
  // Returns 1 time unit after the edge where the DUT is idle again.
  task automatic do_req(input string tag, input noc_packet p);
    noc_packet       er;
    logic [NREG-1:0] ewr;
    bit              has;
    bus.rx_av  = 1'b1;
    bus.rx_dat = p;
    bus.tx_re  = 1'b1;
    #1 chk({tag, ".rx_re_idle"}, bus.rx_re, 1);
    @(posedge ipclk);
    has = model(p, er, ewr);
    #1;
    bus.rx_av = 1'b0;
    chk({tag, ".rx_re_exec"}, bus.rx_re, 0);
    chk({tag, ".tx_av_exec"}, bus.tx_av, 0);
    @(posedge ipclk); #1;
    chk({tag, ".reg_wr"}, reg_wr, ewr);
    chk({tag, ".reg_q"}, reg_q, mvec());
    chk({tag, ".tx_av"}, bus.tx_av, has);
    if (has) begin
      chk({tag, ".tx_dat"}, bus.tx_dat, er);
      @(posedge ipclk); #1;
      chk({tag, ".tx_av_after_push"}, bus.tx_av, 0);
      chk({tag, ".reg_wr_after"}, reg_wr, 0);
    end
  endtask

  initial begin : stim
    noc_packet       p, p2, er;
    logic [NREG-1:0] ewr;
    bit              has;
    noc_packet       reqs [3];
    noc_packet       expq [$];
    int              pop_cyc [3];
    int              qi, npush;
    logic            pop, push;
    noc_packet       pdat;
    int              kind, ri;
    logic [31:0]     a;

    prt_addr = PA;
    prt_num  = PN;
    rst      = 1'b1;
    for (int i = 0; i < NREG; i++) mregs[i] = RV;

    // Reset state. rx_av is high to show that rst blocks the pop.
    bus.rx_av  = 1'b1;
    bus.rx_dat = mk(8'd12, 8'h11, 8'h01, 32'h0, 32'h1);
    bus.tx_re  = 1'b0;
    repeat (2) @(posedge ipclk);
    #1;
    chk("rst.rx_re", bus.rx_re, 0);
    chk("rst.tx_av", bus.tx_av, 0);
    chk("rst.tx_dat", bus.tx_dat, 0);
    chk("rst.reg_wr", reg_wr, 0);
    chk("rst.reg_q", reg_q, mvec());
    bus.rx_av = 1'b0;
    rst       = 1'b0;
    @(posedge ipclk); #1;

    // Directed cases
    do_req("wr08", mk(8'd12, 8'h35, 8'h01, 32'h08, 32'hDEADBEEF));
    chk("wr08.reg2", reg_q[2], 32'hDEADBEEF);
    do_req("rd08", mk(8'd8, 8'h35, 8'h02, 32'h08, $urandom()));
    do_req("rd40", mk(8'd8, 8'h21, 8'h02, 32'h40, $urandom()));
    do_req("rd06", mk(8'd8, 8'h22, 8'h02, 32'h06, $urandom()));
    do_req("wr40", mk(8'd12, 8'h23, 8'h01, 32'h40, 32'h12345678));
    do_req("wrlen8", mk(8'd8, 8'h24, 8'h01, 32'h04, 32'h0BADF00D));
    do_req("rdlen12", mk(8'd12, 8'h25, 8'h02, 32'h08, 32'h0));
    do_req("badop", mk(8'd12, 8'h26, 8'h05, 32'h0C, 32'h55AA55AA));
    do_req("wralias", mk(8'd12, 8'h27, 8'h01, 32'h0001_0008, 32'hCAFEBABE));
    do_req("wr3c", mk(8'd12, 8'h28, 8'h01, 32'h3C, 32'h600DF00D));
    do_req("rd3c", mk(8'd8, 8'h29, 8'h02, 32'h3C, $urandom()));

    // Back-pressure: tx_re low for 10 cycles while another request waits
    p  = mk(8'd12, 8'h41, 8'h01, 32'h10, $urandom());
    p2 = mk(8'd8, 8'h42, 8'h02, 32'h10, $urandom());
    bus.rx_av  = 1'b1;
    bus.rx_dat = p;
    bus.tx_re  = 1'b0;
    @(posedge ipclk);
    has = model(p, er, ewr);
    #1;
    bus.rx_dat = p2;
    @(posedge ipclk); #1;
    for (int i = 0; i < 10; i++) begin
      chk("hold.tx_av", bus.tx_av, 1);
      chk("hold.tx_dat", bus.tx_dat, er);
      chk("hold.rx_re", bus.rx_re, 0);
      @(posedge ipclk); #1;
    end
    bus.tx_re = 1'b1;
    #1 chk("hold.tx_av_push", bus.tx_av, 1);
    @(posedge ipclk); #1;
    chk("hold.one_push", bus.tx_av, 0);
    chk("hold.reg_q", reg_q, mvec());
    do_req("hold.next", p2);

    // Three queued requests with tx_re held high
    reqs[0] = mk(8'd12, 8'h51, 8'h01, 4 * $urandom_range(0, NREG - 1), $urandom());
    reqs[1] = mk(8'd12, 8'h52, 8'h01, 4 * $urandom_range(0, NREG - 1), $urandom());
    reqs[2] = mk(8'd8, 8'h53, 8'h02, reqs[0][63:32], $urandom());
    qi    = 0;
    npush = 0;
    bus.tx_re = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.rx_av = (qi < 3);
      if (qi < 3) bus.rx_dat = reqs[qi];
      #1;
      pop  = bus.rx_re;
      push = bus.tx_av && bus.tx_re;
      pdat = bus.tx_dat;
      @(posedge ipclk);
      if (pop && qi < 3) begin
        pop_cyc[qi] = cyc;
        has = model(reqs[qi], er, ewr);
        expq.push_back(er);
        qi++;
      end
      if (push) begin
        npush++;
        if (expq.size() > 0) chk("b2b.tx_dat", pdat, expq.pop_front());
      end
      #1;
    end
    bus.rx_av = 1'b0;
    chk("b2b.npush", npush, 3);
    chk("b2b.pop0", pop_cyc[0], 0);
    chk("b2b.pop1", pop_cyc[1], 3);
    chk("b2b.pop2", pop_cyc[2], 6);
    chk("b2b.reg_q", reg_q, mvec());

    // Randomized requests against the model
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      ri   = $urandom_range(0, NREG - 1);
      a    = 4 * ri;
      if (kind <= 3) p = mk(8'd12, 8'($urandom()), 8'h01, a, $urandom());
      else if (kind <= 6) p = mk(8'd8, 8'($urandom()), 8'h02, a, $urandom());
      else if (kind == 7) p = mk($urandom_range(0, 1) ? 8'd12 : 8'd8, 8'($urandom()),
                                 $urandom_range(0, 1) ? 8'h01 : 8'h02,
                                 a + $urandom_range(1, 3), $urandom());
      else if (kind == 8) p = mk(8'd12, 8'($urandom()), 8'h01,
                                 $urandom_range(0, 1) ? (NREG * 4 + a) : (a | 32'h8000_0000),
                                 $urandom());
      else p = mk(8'($urandom_range(0, 16)), 8'($urandom()), 8'($urandom()), a, $urandom());
      do_req("rand", p);
    end

    // Reset while a write is in EXEC
    for (int i = 0; i < NREG; i++) begin
      p = mk(8'd12, 8'h61, 8'h01, 4 * i, 32'hC0DE_0000 + i);
      do_req("prefill", p);
    end
    p = mk(8'd12, 8'h62, 8'h01, 32'h14, 32'hFFFF_0001);
    bus.rx_av  = 1'b1;
    bus.rx_dat = p;
    bus.tx_re  = 1'b1;
    @(posedge ipclk); #1;
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) mregs[i] = RV;
    #1;
    chk("midrst.rx_re", bus.rx_re, 0);
    chk("midrst.tx_av", bus.tx_av, 0);
    chk("midrst.tx_dat", bus.tx_dat, 0);
    chk("midrst.reg_wr", reg_wr, 0);
    chk("midrst.reg_q", reg_q, mvec());
    @(posedge ipclk); #1;
    chk("midrst.reg_q_held", reg_q, mvec());
    chk("midrst.tx_av_held", bus.tx_av, 0);
    bus.rx_av = 1'b0;
    rst = 1'b0;
    @(posedge ipclk); #1;
    chk("midrst.no_rsp", bus.tx_av, 0);
    do_req("midrst.rd14", mk(8'd8, 8'h63, 8'h02, 32'h14, $urandom()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
